uart_rx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_sampler.sv | 76 +++++++
 rtl/uart_rx_frame.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Brief   : Shared parity encodings, receiver state type and 3-way vote helper.
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module : uart_bit_sampler
// Brief  : RX synchroniser, per-bit cycle counter and 3-sample majority vote.
// Rev    : 1.0  initial release
// ============================================================================
module uart_bit_sampler #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic count_en,
    output logic rx_s,
    output logic sample_strobe,
    output logic sample_bit
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_M1   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_P1   = CNT_W'(MID + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_vote0;
    logic             r_vote1;

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!count_en) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else begin
            if (r_cnt == CNT_M1) begin
                r_vote0 <= r_sync2;
            end
            if (r_cnt == CNT_MID) begin
                r_vote1 <= r_sync2;
            end
        end
    end

    assign rx_s          = r_sync2;
    assign sample_strobe = count_en && (r_cnt == CNT_P1);
    assign sample_bit    = maj3(r_vote0, r_vote1, r_sync2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_frame
// Brief  : Parametrised UART receiver with error flags and valid/ready output.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    import uart_pkg::*;

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
            $error("uart_rx_frame: CLKS_PER_BIT must be 4 or more");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_frame: DATA_BITS must be 5..9");
        end
        if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
            $error("uart_rx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_rx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int              IDX_W      = 4;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic            STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic            ODD_SENSE  = (PARITY == PAR_ODD);
    localparam logic            HAS_PARITY = (PARITY != PAR_NONE);

    rx_state_t r_state;
    rx_state_t w_state_next;
    logic      w_complete;

    logic rx_s;
    logic w_count_en;
    logic w_strobe;
    logic w_bit;

    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_fe_acc;
    logic                 r_pe_acc;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_fe;
    logic                 r_pe;
    logic                 r_overrun;

    // The counter starts on the same cycle the falling edge is seen so that
    // bit boundaries stay aligned with the line.
    assign w_count_en = (r_state == ST_IDLE) ? ~rx_s : (r_state != ST_WAIT_HIGH);

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .count_en      (w_count_en),
        .rx_s          (rx_s),
        .sample_strobe (w_strobe),
        .sample_bit    (w_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rx_s) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_strobe) w_state_next = w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_strobe && r_bit_idx == IDX_LAST) begin
                    w_state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_strobe) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_strobe && r_stop_idx == STOP_LAST) begin
                    w_complete   = 1'b1;
                    w_state_next = w_bit ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_fe_acc   <= 1'b0;
            r_pe_acc   <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_fe_acc   <= 1'b0;
                    r_pe_acc   <= 1'b0;
                end
                ST_DATA: begin
                    if (w_strobe) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_strobe) r_pe_acc <= (^r_shift) ^ w_bit ^ ODD_SENSE;
                end
                ST_STOP: begin
                    if (w_strobe) begin
                        r_fe_acc   <= r_fe_acc | ~w_bit;
                        r_stop_idx <= r_stop_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new frame may replace the held word only if it is being accepted in
    // the same cycle; otherwise it is dropped and flagged as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_fe      <= 1'b0;
            r_pe      <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || data_ready) begin
                r_data  <= r_shift;
                r_fe    <= r_fe_acc | ~w_bit;
                r_pe    <= r_pe_acc;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && data_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_fe;
    assign parity_err = r_pe;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_frame
// Brief  : Directed bench for uart_rx_frame (8N1 instance and 8E1 instance).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx_a, rx_p;
    logic       ready_a, ready_p;
    logic [7:0] data_a, data_p;
    logic       valid_a, valid_p;
    logic       fe_a, fe_p, pe_a, pe_p;
    logic       ovr_a, ovr_p, busy_a, busy_p;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int stop_cyc = 0;
    int vcyc_a = 0;
    int rise_cyc_a = 0;
    logic prev_valid_a = 1'b0;

    logic [7:0] qa_data[$];
    logic       qa_fe[$];
    logic       qa_pe[$];
    logic [7:0] qp_data[$];
    logic       qp_fe[$];
    logic       qp_pe[$];

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY       (0),
        .STOP_BITS    (1)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_a),
        .data       (data_a),
        .data_valid (valid_a),
        .data_ready (ready_a),
        .frame_err  (fe_a),
        .parity_err (pe_a),
        .overrun    (ovr_a),
        .busy       (busy_a)
    );

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY       (2),
        .STOP_BITS    (1)
    ) dut_p (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_p),
        .data       (data_p),
        .data_valid (valid_p),
        .data_ready (ready_p),
        .frame_err  (fe_p),
        .parity_err (pe_p),
        .overrun    (ovr_p),
        .busy       (busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid_a) begin
            vcyc_a <= vcyc_a + 1;
            if (!prev_valid_a) rise_cyc_a <= cyc;
            if (ready_a) begin
                qa_data.push_back(data_a);
                qa_fe.push_back(fe_a);
                qa_pe.push_back(pe_a);
            end
        end
        prev_valid_a <= valid_a;
        if (valid_p && ready_p) begin
            qp_data.push_back(data_p);
            qp_fe.push_back(fe_p);
            qp_pe.push_back(pe_p);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // gbit/gcyc select a single-cycle inversion (frame bit index, cycle in bit).
    task automatic send_frame(input bit to_p, input logic [7:0] b, input bit with_par,
                              input logic pbit, input int gbit, input int gcyc);
        logic [10:0] fr;
        int          nbits;
        logic        v;
        if (with_par) begin
            fr    = {1'b1, pbit, b, 1'b0};
            nbits = 11;
        end else begin
            fr    = {2'b11, b, 1'b0};
            nbits = 10;
        end
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                #1;
                if (c == 0 && i == nbits - 1) stop_cyc = cyc;
                v = fr[i] ^ ((i == gbit) && (c == gcyc));
                if (to_p) rx_p = v;
                else      rx_a = v;
            end
        end
    endtask

    initial begin
        int base;
        int v0;
        rst_n   = 1'b0;
        rx_a    = 1'b1;
        rx_p    = 1'b1;
        ready_a = 1'b1;
        ready_p = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_data", data_a, 8'h00);
        check("rst_valid", valid_a, 1'b0);
        check("rst_frame_err", fe_a, 1'b0);
        check("rst_parity_err", pe_a, 1'b0);
        check("rst_overrun", ovr_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(5);

        // 8N1 basic frame
        base = qa_data.size();
        v0   = vcyc_a;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, -1, 0);
        idle(20);
        @(negedge clk);
        check("t1_count", qa_data.size() - base, 1);
        check("t1_data", qa_data[base], 8'hA5);
        check("t1_frame_err", qa_fe[base], 1'b0);
        check("t1_parity_err", qa_pe[base], 1'b0);
        check("t1_valid_cycles", vcyc_a - v0, 1);
        check("t1_latency", rise_cyc_a - stop_cyc, CPB / 2 + 4);

        // Even parity: 0x3C has four ones
        base = qp_data.size();
        send_frame(1'b1, 8'h3C, 1'b1, 1'b1, -1, 0);
        idle(20);
        send_frame(1'b1, 8'h3C, 1'b1, 1'b0, -1, 0);
        idle(20);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, -1, 0);
        idle(20);
        @(negedge clk);
        check("t2_count", qp_data.size() - base, 3);
        check("t2_bad_data", qp_data[base], 8'h3C);
        check("t2_bad_parity_err", qp_pe[base], 1'b1);
        check("t2_bad_frame_err", qp_fe[base], 1'b0);
        check("t2_good_data", qp_data[base+1], 8'h3C);
        check("t2_good_parity_err", qp_pe[base+1], 1'b0);
        check("t2_odd_data_parity_err", qp_pe[base+2], 1'b0);

        // False start
        base = qa_data.size();
        @(posedge clk); #1; rx_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t3_busy_high", busy_a, 1'b1);
        @(posedge clk); #1; rx_a = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t3_busy_dropped", busy_a, 1'b0);
        idle(20);
        @(negedge clk);
        check("t3_no_word", qa_data.size() - base, 0);

        // Glitch at centre of data bit 3 (frame bit 4)
        base = qa_data.size();
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 4, CPB / 2);
        idle(20);
        @(negedge clk);
        check("t4_count", qa_data.size() - base, 1);
        check("t4_data", qa_data[base], 8'h00);
        check("t4_frame_err", qa_fe[base], 1'b0);

        // Overrun
        @(posedge clk); #1; ready_a = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, -1, 0);
        idle(20);
        @(negedge clk);
        check("t5_first_valid", valid_a, 1'b1);
        check("t5_first_data", data_a, 8'h11);
        check("t5_no_overrun_yet", ovr_a, 1'b0);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, -1, 0);
        idle(20);
        @(negedge clk);
        check("t5_held_valid", valid_a, 1'b1);
        check("t5_held_data", data_a, 8'h11);
        check("t5_overrun", ovr_a, 1'b1);
        base = qa_data.size();
        @(posedge clk); #1; ready_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_accept_count", qa_data.size() - base, 1);
        check("t5_accept_data", qa_data[base], 8'h11);
        check("t5_valid_dropped", valid_a, 1'b0);
        check("t5_overrun_sticky", ovr_a, 1'b1);

        // Break: line low for three frame times
        base = qa_data.size();
        @(posedge clk); #1; rx_a = 1'b0;
        repeat (3 * 10 * CPB) @(posedge clk);
        @(negedge clk);
        check("t6_break_busy", busy_a, 1'b1);
        @(posedge clk); #1; rx_a = 1'b1;
        idle(32);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, -1, 0);
        idle(20);
        @(negedge clk);
        check("t6_count", qa_data.size() - base, 2);
        check("t6_break_data", qa_data[base], 8'h00);
        check("t6_break_frame_err", qa_fe[base], 1'b1);
        check("t6_next_data", qa_data[base+1], 8'h55);
        check("t6_next_frame_err", qa_fe[base+1], 1'b0);

        // Reset in the middle of a frame
        @(posedge clk); #1; rx_a = 1'b0;
        repeat (CPB) @(posedge clk);
        #1; rx_a = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t7_rst_data", data_a, 8'h00);
        check("t7_rst_valid", valid_a, 1'b0);
        check("t7_rst_frame_err", fe_a, 1'b0);
        check("t7_rst_parity_err", pe_a, 1'b0);
        check("t7_rst_overrun", ovr_a, 1'b0);
        check("t7_rst_busy", busy_a, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(5);
        base = qa_data.size();
        send_frame(1'b0, 8'h9C, 1'b0, 1'b0, -1, 0);
        idle(20);
        @(negedge clk);
        check("t7_count", qa_data.size() - base, 1);
        check("t7_data", qa_data[base], 8'h9C);
        check("t7_frame_err", qa_fe[base], 1'b0);
        check("p_overrun_clear", ovr_p, 1'b0);
        check("p_busy_idle", busy_p, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
